// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a small prefetch queue between the ROM and decode.
// Issues at most one ROM read per cycle and asks the PC stage to hold when the queue cannot absorb another.
module fetch_stage #(
    parameter int D     = 12,
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [D-1:0] PrgCtr,
    input  logic         Flush,
    input  logic [W-1:0] InstrRdata,
    input  logic         DecReady,
    output logic [D-1:0] InstrAddr,
    output logic         InstrReq,
    output logic         HoldReq,
    output logic [D-1:0] HoldTarget,
    output logic         FetchValid,
    output logic [W-1:0] FetchInstr,
    output logic [D-1:0] FetchPc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          infl_q, infl_d;
    logic [D-1:0]  infl_pc_q, infl_pc_d;
    logic [W-1:0]  instr_mem [DEPTH];
    logic [D-1:0]  pc_mem [DEPTH];
    logic          issue, push, pop;

    // Issue looks only at registered occupancy so a pop never feeds back into InstrReq.
    always_comb begin
        issue     = !Reset && !Flush && ((cnt_q + CW'(infl_q)) < CW'(DEPTH));
        push      = !Reset && !Flush && infl_q;
        pop       = !Reset && !Flush && (cnt_q != '0) && DecReady;
        cnt_d     = Flush ? '0 : cnt_q + CW'(push) - CW'(pop);
        wptr_d    = Flush ? '0 : wptr_q + PW'(push);
        rptr_d    = Flush ? '0 : rptr_q + PW'(pop);
        infl_d    = issue;
        infl_pc_d = issue ? PrgCtr : infl_pc_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            infl_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            infl_q <= infl_d;
        end
        infl_pc_q <= infl_pc_d;
        if (push) begin
            instr_mem[wptr_q] <= InstrRdata;
            pc_mem[wptr_q]    <= infl_pc_q;
        end
    end

    always @(posedge Clk)
        if (push && !pop)
            assert (cnt_q != CW'(DEPTH));

    always_comb begin
        InstrAddr  = PrgCtr;
        InstrReq   = issue;
        HoldReq    = !Reset && !Flush && !issue;
        HoldTarget = PrgCtr;
        FetchValid = !Reset && (cnt_q != '0);
        FetchInstr = instr_mem[rptr_q];
        FetchPc    = pc_mem[rptr_q];
    end
endmodule
